// File: rtl/prog_mem_ctrl.sv
// ---------------------------------------------------------------------------
// prog_mem_ctrl
//   Parametrised instruction memory for the fetch stage. The memory is
//   boot-loaded over a write port while in LOAD. In RUN it serves registered
//   fetches with one cycle of latency and honours stall. Fetch stops when a
//   word whose opcode field matches HALT_OPC is registered, which moves the
//   block to HALT.
//
// Parameters
//   DATA_W     instruction width
//   ADDR_W     address width
//   DEPTH      implemented words (<= 2**ADDR_W)
//   NOP_WORD   word driven when no valid instruction is held
//   HALT_OPC   opcode value in bits [6:0] that terminates fetch
//   BOOT_RUN   0: leave reset in LOAD, 1: leave reset in RUN
//   INIT_FILE  optional boot image name
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   ld_we        load write strobe (accepted in LOAD only)
//   ld_addr      load write address
//   ld_data      load write data
//   ld_done      end of load, move to RUN
//   load_req     from RUN/HALT, re-enter LOAD
//   restart      from HALT, return to RUN
//   fetch_req    fetch request for fetch_addr
//   fetch_addr   fetch address
//   stall        hold instruction / instr_valid
//   instruction  registered fetched word
//   instr_valid  instruction holds a fetched word
//   halted       state is HALT
//   loading      state is LOAD
//   ld_count     accepted load writes since entering LOAD (saturates at DEPTH)
//   addr_err     one-cycle pulse, out-of-range fetch or load address
//   ld_err       one-cycle pulse, ld_we outside LOAD (write dropped)
// ---------------------------------------------------------------------------
module prog_mem_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 5,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0,
  parameter logic [6:0]        HALT_OPC  = 7'b1010101,
  parameter bit                BOOT_RUN  = 1'b0,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  input  logic              load_req,
  input  logic              restart,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              halted,
  output logic              loading,
  output logic [ADDR_W:0]   ld_count,
  output logic              addr_err,
  output logic              ld_err
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam state_t          RESET_ST = BOOT_RUN ? ST_RUN : ST_LOAD;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ld_in_range;
  logic              fetch_in_range;
  logic              ld_accept;
  logic [DATA_W-1:0] rd_word;

  // Saturating increment of the load counter; it never wraps past DEPTH.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] count);
    if (count == DEPTH_C) begin
      return count;
    end
    return count + (ADDR_W+1)'(1);
  endfunction

  function automatic logic is_halt(input logic [DATA_W-1:0] word);
    return word[6:0] == HALT_OPC;
  endfunction

  // Address decode (DEPTH may be smaller than the address space)
  always_comb begin
    ld_in_range    = {1'b0, ld_addr}    < DEPTH_C;
    fetch_in_range = {1'b0, fetch_addr} < DEPTH_C;
    ld_accept      = ld_we && (state == ST_LOAD) && ld_in_range;
    rd_word        = NOP_WORD;
    if (fetch_in_range) begin
      rd_word = mem[fetch_addr];
    end
  end

  // Storage write port: no reset, contents persist across reset
  always_ff @(posedge clk) begin
    if (ld_accept) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Control and registered fetch output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RESET_ST;
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      ld_count    <= '0;
      addr_err    <= 1'b0;
      ld_err      <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      ld_err   <= 1'b0;

      // Load port bookkeeping; the array write itself happens above.
      if (ld_we) begin
        if (state == ST_LOAD) begin
          if (ld_in_range) begin
            ld_count <= sat_inc(ld_count);
          end else begin
            addr_err <= 1'b1;
          end
        end else begin
          ld_err <= 1'b1;
        end
      end

      case (state)
        ST_LOAD: begin
          instruction <= NOP_WORD;
          instr_valid <= 1'b0;
          if (ld_done) begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (load_req) begin
            // Leaving for LOAD takes priority over any fetch this cycle.
            state       <= ST_LOAD;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            ld_count    <= '0;
          end else if (!stall) begin
            if (fetch_req) begin
              instr_valid <= 1'b1;
              if (fetch_in_range) begin
                instruction <= rd_word;
                // The halt word itself is presented valid on this edge.
                if (is_halt(rd_word)) begin
                  state <= ST_HALT;
                end
              end else begin
                instruction <= NOP_WORD;
                addr_err    <= 1'b1;
              end
            end else begin
              instruction <= NOP_WORD;
              instr_valid <= 1'b0;
            end
          end
        end

        ST_HALT: begin
          if (load_req) begin
            // load_req beats restart when both arrive together.
            state       <= ST_LOAD;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            ld_count    <= '0;
          end else begin
            if (restart) begin
              state <= ST_RUN;
            end
            // Fetches are ignored; the halt word drains on the first unstalled cycle.
            if (!stall) begin
              instruction <= NOP_WORD;
              instr_valid <= 1'b0;
            end
          end
        end

        default: begin
          state       <= RESET_ST;
          instruction <= NOP_WORD;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign halted  = (state == ST_HALT);
  assign loading = (state == ST_LOAD);

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_ctrl
//   Directed bench for prog_mem_ctrl. Two instances share every input: "a"
//   is built with DEPTH=32, "b" with DEPTH=24 so out-of-range addresses can
//   be exercised on the same stimulus.
// ---------------------------------------------------------------------------
module tb_prog_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic              load_req;
  logic              restart;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;

  logic [DATA_W-1:0] a_instruction, b_instruction;
  logic              a_instr_valid, b_instr_valid;
  logic              a_halted, b_halted;
  logic              a_loading, b_loading;
  logic [ADDR_W:0]   a_ld_count, b_ld_count;
  logic              a_addr_err, b_addr_err;
  logic              a_ld_err, b_ld_err;

  int errors = 0;
  int checks = 0;

  prog_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(32)) dut_a (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_done(ld_done), .load_req(load_req), .restart(restart), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .stall(stall), .instruction(a_instruction),
    .instr_valid(a_instr_valid), .halted(a_halted), .loading(a_loading),
    .ld_count(a_ld_count), .addr_err(a_addr_err), .ld_err(a_ld_err)
  );

  prog_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(24)) dut_b (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_done(ld_done), .load_req(load_req), .restart(restart), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .stall(stall), .instruction(b_instruction),
    .instr_valid(b_instr_valid), .halted(b_halted), .loading(b_loading),
    .ld_count(b_ld_count), .addr_err(b_addr_err), .ld_err(b_ld_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    ld_we   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_we   = 1'b0;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
  endtask

  initial begin
    reset = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    load_req = 1'b0; restart = 1'b0; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_loading", 32'(a_loading), 32'd1);
    check("rst_valid", 32'(a_instr_valid), 32'd0);
    check("rst_instr", a_instruction, 32'h0);
    check("rst_count", 32'(a_ld_count), 32'd0);
    check("rst_halted", 32'(a_halted), 32'd0);
    check("rst_addr_err", 32'(a_addr_err), 32'd0);
    @(negedge clk) reset = 1'b1;

    // Boot load; last write lands in the same cycle as ld_done
    load_word(5'd0, 32'h0010_0293);
    check("ld_count_1", 32'(a_ld_count), 32'd1);
    load_word(5'd1, 32'h0040_0313);
    load_word(5'd3, 32'h00A0_0393);
    check("ld_count_3", 32'(a_ld_count), 32'd3);
    check("still_loading", 32'(a_loading), 32'd1);
    ld_done = 1'b1;
    load_word(5'd30, 32'h1234_5678);
    ld_done = 1'b0;
    check("loading_fell", 32'(a_loading), 32'd0);
    check("a_count_done_we", 32'(a_ld_count), 32'd4);
    check("b_count_oor", 32'(b_ld_count), 32'd3);
    check("b_ld_addr_err", 32'(b_addr_err), 32'd1);
    check("a_ld_addr_ok", 32'(a_addr_err), 32'd0);

    // Fetch with one-cycle latency
    fetch(5'd0);
    check("fetch0", a_instruction, 32'h0010_0293);
    check("fetch0_valid", 32'(a_instr_valid), 32'd1);
    fetch(5'd1);
    check("fetch1", a_instruction, 32'h0040_0313);
    fetch_req = 1'b0;
    tick();
    check("idle_instr", a_instruction, 32'h0);
    check("idle_valid", 32'(a_instr_valid), 32'd0);

    // Stall holds the output for three cycles
    fetch(5'd1);
    stall = 1'b1;
    fetch_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", a_instruction, 32'h0040_0313);
      check("stall_valid", 32'(a_instr_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    check("post_stall", a_instruction, 32'h00A0_0393);

    // Out-of-range fetch on the 24-deep instance
    fetch(5'd30);
    check("b_oor_instr", b_instruction, 32'h0);
    check("b_oor_valid", 32'(b_instr_valid), 32'd1);
    check("b_oor_err", 32'(b_addr_err), 32'd1);
    check("a_fetch30", a_instruction, 32'h1234_5678);
    check("a_fetch30_err", 32'(a_addr_err), 32'd0);
    fetch_req = 1'b0;
    tick();
    check("b_err_pulse", 32'(b_addr_err), 32'd0);

    // Write attempt in RUN is dropped
    load_word(5'd0, 32'hDEAD_BEEF);
    check("ld_err_run", 32'(a_ld_err), 32'd1);
    fetch(5'd0);
    check("ld_err_pulse", 32'(a_ld_err), 32'd0);
    check("mem_unchanged", a_instruction, 32'h0010_0293);

    // load_req with a concurrent fetch: no fetch, back to LOAD
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    fetch_req = 1'b0;
    check("reload_loading", 32'(a_loading), 32'd1);
    check("reload_count", 32'(a_ld_count), 32'd0);
    check("reload_valid", 32'(a_instr_valid), 32'd0);
    ld_done = 1'b1;
    load_word(5'd2, 32'h0000_0055);
    ld_done = 1'b0;
    check("reload_count1", 32'(a_ld_count), 32'd1);

    // Halt detection
    fetch(5'd0);
    fetch(5'd1);
    check("pre_halt", 32'(a_halted), 32'd0);
    fetch(5'd2);
    check("halt_word", a_instruction, 32'h0000_0055);
    check("halt_valid", 32'(a_instr_valid), 32'd1);
    check("halted", 32'(a_halted), 32'd1);
    fetch(5'd0);
    check("halt_ignore_instr", a_instruction, 32'h0);
    check("halt_ignore_valid", 32'(a_instr_valid), 32'd0);
    check("still_halted", 32'(a_halted), 32'd1);
    fetch_req = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart", 32'(a_halted), 32'd0);
    fetch(5'd0);
    check("restart_fetch", a_instruction, 32'h0010_0293);

    // Halt again, then load_req and restart together: LOAD wins
    fetch(5'd2);
    check("halted2", 32'(b_halted), 32'd1);
    fetch_req = 1'b0;
    load_req = 1'b1;
    restart = 1'b1;
    tick();
    load_req = 1'b0;
    restart = 1'b0;
    check("both_loading", 32'(a_loading), 32'd1);
    check("both_halted", 32'(a_halted), 32'd0);

    // 40 writes: counter saturates at DEPTH
    for (int i = 0; i < 40; i++) begin
      load_word(ADDR_W'(i), 32'h0100_0013 | (32'(i) << 12));
    end
    check("a_count_sat", 32'(a_ld_count), 32'd32);
    check("b_count_sat", 32'(b_ld_count), 32'd24);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    fetch(5'd5);
    check("rewrite5", a_instruction, 32'h0102_5013);
    fetch(5'd20);
    check("word20", a_instruction, 32'h0101_4013);

    // Reset in the middle of a load keeps written words
    fetch_req = 1'b0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    load_word(5'd10, 32'hAAAA_0013);
    load_word(5'd11, 32'hBBBB_0013);
    load_word(5'd12, 32'hCCCC_0013);
    check("mid_count", 32'(a_ld_count), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_loading", 32'(a_loading), 32'd1);
    check("mid_rst_count", 32'(a_ld_count), 32'd0);
    @(negedge clk) reset = 1'b1;
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    fetch(5'd10);
    check("keep10", a_instruction, 32'hAAAA_0013);
    fetch(5'd11);
    check("keep11", a_instruction, 32'hBBBB_0013);
    fetch(5'd12);
    check("keep12", a_instruction, 32'hCCCC_0013);
    fetch_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
